// File: rtl/x_pulse_conditioner.sv
// Raw button/switch conditioner: synchronises raw_in, debounces it with a
// run-length qualified 4-state FSM and emits one-cycle rise/fall pulses.
module x_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic x,
  output logic x_fall,
  output logic level,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_x;
  logic                   r_x_fall;
  logic                   r_level;
  logic                   w_sync_q;
  logic [CW-1:0]          w_cnt_inc;

  assign w_sync_q  = r_sync[SYNC_STAGES-1];
  // Saturating increment: the run length can never wrap back to a small value.
  assign w_cnt_inc = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_x      <= 1'b0;
      r_x_fall <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_x      <= 1'b0;
      r_x_fall <= 1'b0;
      case (r_state)
        LOW: begin
          if (w_sync_q) begin
            r_state <= RISE;
            r_cnt   <= CW'(1);
          end
        end
        RISE: begin
          if (!w_sync_q) begin
            r_state <= LOW;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_x     <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HIGH: begin
          if (!w_sync_q) begin
            r_state <= FALL;
            r_cnt   <= CW'(1);
          end
        end
        FALL: begin
          // A return to 1 mid-qualification cancels the fall silently.
          if (w_sync_q) begin
            r_state <= HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_x_fall <= 1'b1;
            r_level  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign x      = r_x;
  assign x_fall = r_x_fall;
  assign level  = r_level;
  assign busy   = (r_state == RISE) || (r_state == FALL);

endmodule

// File: tb/tb_x_pulse_conditioner.sv
// Bench for x_pulse_conditioner: directed scenarios plus random bouncing input,
// every cycle compared against a run-length reference model.
module tb_x_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int D    = 4;

  logic clock;
  logic reset;
  logic raw_in;
  logic x;
  logic x_fall;
  logic level;
  logic busy;

  x_pulse_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .raw_in(raw_in),
    .x     (x),
    .x_fall(x_fall),
    .level (level),
    .busy  (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #20 clock = ~clock;

  // reference model state and scoreboard
  logic [3:0] exp_q[$];
  bit         raw_hist[$];
  int         m_run;
  bit         m_level;
  int         errors;
  int         checks;
  int         nx;
  int         nf;

  // Accepted level flips after D consecutive synchronised samples that disagree
  // with it; the synchronised sample is raw_in as seen SYNC edges earlier.
  task automatic model_edge(input bit r, input bit rst);
    bit s;
    bit px;
    bit pf;
    px = 1'b0;
    pf = 1'b0;
    if (rst) begin
      raw_hist.delete();
      m_run   = 0;
      m_level = 1'b0;
    end else begin
      s = (raw_hist.size() >= SYNC) ? raw_hist[SYNC-1] : 1'b0;
      raw_hist.push_front(r);
      if (raw_hist.size() > SYNC) void'(raw_hist.pop_back());
      if (s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = ~m_level;
          m_run   = 0;
          px      = m_level;
          pf      = ~m_level;
        end
      end else begin
        m_run = 0;
      end
    end
    exp_q.push_back({px, pf, m_level, (m_run != 0)});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: apply inputs, clock once, advance model, compare all outputs
  task automatic tick(input bit r, input bit rst, input string tag);
    logic [3:0] expv;
    raw_in = r;
    reset  = rst;
    @(posedge clock);
    model_edge(r, rst);
    #1;
    expv = exp_q.pop_front();
    check(tag, {28'd0, x, x_fall, level, busy}, {28'd0, expv});
    if (x) nx++;
    if (x_fall) nf++;
  endtask

  initial begin
    int x_at;
    int busy_cnt;
    int wait_cnt;
    int run_len;
    bit rv;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    raw_in = 1'b0;
    m_run  = 0;
    m_level = 1'b0;

    // T1 reset
    tick(0, 1, "t1_reset");
    tick(0, 1, "t1_reset");
    check("t1_outs_zero", {28'd0, x, x_fall, level, busy}, 32'd0);
    for (int i = 0; i < 3; i++) tick(0, 0, "t1_idle");

    // T2 clean rise: x five edges after the first sampling edge
    nx = 0; x_at = -1; busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, "t2_rise");
      if (x && x_at < 0) x_at = i;
      if (i < 5 && busy) busy_cnt++;
    end
    check("t2_x_latency", x_at, 5);
    check("t2_x_count", nx, 1);
    check("t2_busy_before", busy_cnt, 3);
    check("t2_level_high", {31'd0, level}, 32'd1);

    // T4 bouncing release
    nx = 0; nf = 0;
    tick(1, 0, "t4_bounce"); tick(0, 0, "t4_bounce");
    tick(1, 0, "t4_bounce"); tick(0, 0, "t4_bounce");
    for (int i = 0; i < 12; i++) tick(0, 0, "t4_hold0");
    check("t4_fall_count", nf, 1);
    check("t4_no_rise", nx, 0);
    check("t4_level_low", {31'd0, level}, 32'd0);

    // T3 short pulse rejected
    nx = 0;
    tick(1, 0, "t3_short"); tick(1, 0, "t3_short");
    for (int i = 0; i < 8; i++) tick(0, 0, "t3_low");
    check("t3_no_x", nx, 0);
    check("t3_level_busy", {30'd0, level, busy}, 32'd0);

    // T5 reset while qualifying a rise
    wait_cnt = 0;
    do begin
      tick(1, 0, "t5_rise");
      wait_cnt++;
    end while (!busy && wait_cnt < 10);
    check("t5_reached_busy", {31'd0, busy}, 32'd1);
    nx = 0;
    tick(0, 1, "t5_reset");
    check("t5_after_reset", {30'd0, busy, level}, 32'd0);
    for (int i = 0; i < 10; i++) tick(0, 0, "t5_low");
    check("t5_no_x", nx, 0);

    // raw held high across reset release: exactly one x
    nx = 0;
    for (int i = 0; i < 3; i++) tick(1, 1, "hold_reset");
    for (int i = 0; i < 12; i++) tick(1, 0, "hold_release");
    check("hold_one_x", nx, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, "hold_drop");

    // T6 four clean presses
    nx = 0; nf = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) tick(1, 0, "t6_press");
      for (int i = 0; i < 6; i++) tick(0, 0, "t6_gap");
    end
    check("t6_x_count", nx, 4);
    check("t6_fall_count", nf, 4);

    // random bouncing input with occasional resets
    for (int n = 0; n < 80; n++) begin
      rv      = 1'($urandom_range(0, 1));
      run_len = $urandom_range(1, 7);
      for (int i = 0; i < run_len; i++) begin
        tick(rv, ($urandom_range(0, 49) == 0), "rand");
        check("rand_exclusive", {30'd0, x, x_fall} == 2'b11, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
